sp_sync_ram_ctrl: RTL and testbench
===================================

Name: sp_sync_ram_ctrl

Overview:
Initiator-side controller for the single-port synchronous RAM (cs/we/oe, shared tristate data bus). It accepts burst read/write requests on a valid/ready handshake, streams write data in and read data out, and generates addresses with wrap-around. Bus turnaround is handled internally so the bus is never double-driven. It sits between the LDPC decoder's message-memory sequencer and each RAM bank.

Parameters:
ADDR_WIDTH, 4, RAM address width; a burst may cover up to 2**ADDR_WIDTH words
DATA_WIDTH, 16, RAM word width

Ports:
clk  input  1  single clock, all activity on the rising edge
rst_n  input  1  asynchronous, active-low reset
req_valid  input  1  burst request valid
req_ready  output  1  controller can accept a request (high only in IDLE)
req_write  input  1  1 = write burst, 0 = read burst
req_addr  input  ADDR_WIDTH  burst start address
req_len  input  ADDR_WIDTH  burst length minus one (beats = req_len+1)
wr_valid  input  1  write beat valid
wr_ready  output  1  write beat accepted
wr_data  input  DATA_WIDTH  write beat data
rd_valid  output  1  read beat valid (no backpressure)
rd_data  output  DATA_WIDTH  read beat data, registered
done  output  1  one-cycle pulse when a burst completes
ram_cs  output  1  RAM chip select
ram_we  output  1  RAM write enable
ram_oe  output  1  RAM output enable
ram_addr  output  ADDR_WIDTH  RAM address
ram_data  inout  DATA_WIDTH  shared data bus; driven by the controller only in WR beats, high-Z otherwise

Behaviour:
- Reset (async, rst_n=0): state=IDLE. req_ready=1 once rst_n is released. wr_ready=0, rd_valid=0, rd_data=0, done=0, ram_cs=ram_we=ram_oe=0, ram_addr=0, ram_data high-Z. Reset mid-burst aborts the burst without a done pulse.
- RAM contract: a write occurs at the edge where cs&we. A read registers mem[addr] at the edge where cs&!we. The RAM drives the bus while cs&oe&!we.
- States: IDLE, WR, RD, RD_TAIL, TURN. Beat counter cnt is ADDR_WIDTH+1 bits. ram_addr = base+cnt mod 2**ADDR_WIDTH.
- IDLE: req_ready=1. When req_valid is high, latch addr/len/write, clear cnt, then go to WR (write) or RD (read).
- WR:
  - wr_ready=1.
  - Beat accepted when wr_valid=1: ram_cs=ram_we=1, ram_oe=0, ram_data=wr_data, ram_addr=base+cnt; cnt++.
  - When wr_valid=0: cs=we=0, bus high-Z, counter holds (stall).
  - After the last beat (cnt==len): done=1 next cycle, go to IDLE.
  - Write-to-write and write-to-read need no idle gap.
- RD:
  - ram_cs=1, ram_we=0, ram_oe=1, ram_addr=base+cnt; cnt++ every cycle, no stalls.
  - After issuing address cnt==len, go to RD_TAIL.
- RD_TAIL: cs=1, oe=1, we=0, address held. Go to TURN.
- Read capture: rd_data samples ram_data at the edge after each address cycle. rd_valid is high in the following cycle. Address issued in cycle N gives rd_valid in cycle N+2, one per beat, consecutive.
- TURN: cs=oe=we=0, bus high-Z. The last rd_valid and done=1 occur in this cycle. Go to IDLE.
  - This forces one idle cycle between a read burst and any following access.
- Wrap: base=14, len=3 gives addresses 14,15,0,1.
- Max burst: len=2**ADDR_WIDTH-1 covers all words exactly once.
- Simultaneous events:
  - req_valid is ignored outside IDLE.
  - wr_valid is ignored outside WR; wr_ready=0 there.
  - A request arriving in the same cycle as done is accepted only in the next IDLE cycle.

Decomposition:
- Shared package: state enum {IDLE, WR, RD, RD_TAIL, TURN} and RAM-contract constant RAM_RD_LAT=1.
- One natural sub-module, ram_burst_addr_gen: base/len latch, beat counter, wrapped address, last-beat flag.
- FSM, bus tristate and read capture stay in the top module.

Test Plan:
- Write burst, addr=0, len=15, wr_valid held high, data=$random -> 16 consecutive cs&we cycles, addresses 0..15, done pulses once after beat 15.
- Read-back of the same range -> rd_valid high for exactly 16 consecutive cycles, starting 2 cycles after the first address, rd_data matches the written values in order. TURN cycle shows cs=oe=0 with the bus high-Z.
- Write burst addr=14, len=3 with wr_valid toggling 1,0,1,0,... -> writes land at 14,15,0,1. No cs during gaps. Exactly 4 writes.
- Read immediately followed by a write request -> one TURN cycle where the controller never drives ram_data while ram_oe=1 (contention assertion on every cycle).
- rst_n pulsed low during beat 5 of a 16-beat read -> outputs return to reset values immediately, no done pulse. A following len=0 write at addr 3 completes normally.

Source files
------------

// File: rtl/sp_sync_ram_ctrl_pkg.sv
// Shared FSM encoding and RAM timing contract for the single-port RAM controller.
package sp_sync_ram_ctrl_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_WR      = 3'd1;
    localparam logic [STATE_W-1:0] ST_RD      = 3'd2;
    localparam logic [STATE_W-1:0] ST_RD_TAIL = 3'd3;
    localparam logic [STATE_W-1:0] ST_TURN    = 3'd4;

    // Cycles from an address cycle until the RAM presents that word on the bus.
    localparam int unsigned RAM_RD_LAT = 1;

endpackage

// File: rtl/ram_burst_addr_gen.sv
// Burst address generator: latches base/length, counts beats, wraps the address.
module ram_burst_addr_gen #(
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  inc_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [ADDR_WIDTH-1:0] len_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    // The counter parks on the last beat so a trailing hold cycle keeps the final address.
    always_comb begin
        base_d = base_q;
        len_d  = len_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            base_d = base_i;
            len_d  = len_i;
            cnt_d  = '0;
        end else if (inc_i && !last_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
        end else begin
            base_q <= base_d;
            len_q  <= len_d;
            cnt_q  <= cnt_d;
        end
    end

    assign last_o = (cnt_q == {1'b0, len_q});
    assign addr_o = base_q + cnt_q[ADDR_WIDTH-1:0];

endmodule

// File: rtl/sp_sync_ram_ctrl.sv
// Burst controller for a single-port synchronous RAM with a shared tristate data bus.
module sp_sync_ram_ctrl
    import sp_sync_ram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [ADDR_WIDTH-1:0] req_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  done,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

    logic [STATE_W-1:0]    state_q, state_d;
    logic                  load, inc, wr_beat, rd_issue, rd_hold, done_d;
    logic                  done_q, rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [RAM_RD_LAT-1:0] cap_q;
    logic [ADDR_WIDTH-1:0] gen_addr;
    logic                  gen_last;

    ram_burst_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .inc_i  (inc),
        .base_i (req_addr),
        .len_i  (req_len),
        .addr_o (gen_addr),
        .last_o (gen_last)
    );

    // Next-state and per-cycle bus strobes.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        inc      = 1'b0;
        wr_beat  = 1'b0;
        rd_issue = 1'b0;
        rd_hold  = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    load    = 1'b1;
                    state_d = req_write ? ST_WR : ST_RD;
                end
            end
            ST_WR: begin
                if (wr_valid) begin
                    wr_beat = 1'b1;
                    inc     = 1'b1;
                    if (gen_last) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RD: begin
                rd_issue = 1'b1;
                inc      = 1'b1;
                if (gen_last) begin
                    state_d = ST_RD_TAIL;
                end
            end
            ST_RD_TAIL: begin
                rd_hold = 1'b1;
                done_d  = 1'b1;
                state_d = ST_TURN;
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            done_q     <= 1'b0;
            cap_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            cap_q      <= RAM_RD_LAT'({cap_q, rd_issue});
            rd_valid_q <= cap_q[RAM_RD_LAT-1];
            if (cap_q[RAM_RD_LAT-1]) begin
                rd_data_q <= ram_data;
            end
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign wr_ready  = (state_q == ST_WR);
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign done      = done_q;

    assign ram_cs   = wr_beat | rd_issue | rd_hold;
    assign ram_we   = wr_beat;
    assign ram_oe   = rd_issue | rd_hold;
    assign ram_addr = ram_cs ? gen_addr : '0;
    // Only a write beat drives the bus; the RAM owns it otherwise.
    assign ram_data = wr_beat ? wr_data : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sp_sync_ram_ctrl.sv
// Randomized self-checking bench for sp_sync_ram_ctrl with a behavioural RAM and reference memory.
module tb_sp_sync_ram_ctrl;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [AW-1:0] req_len = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          done;
    logic          ram_cs, ram_we, ram_oe;
    logic [AW-1:0] ram_addr;
    wire  [DW-1:0] ram_data;

    always #5 clk = ~clk;

    sp_sync_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .done      (done),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_oe    (ram_oe),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data)
    );

    // Behavioural RAM following the cs/we/oe contract
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ram_rd_q = '0;
    initial for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
    always @(posedge clk) begin
        if (ram_cs && ram_we) mem[ram_addr] <= ram_data;
        if (ram_cs && !ram_we) ram_rd_q <= mem[ram_addr];
    end
    assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_rd_q : {DW{1'bz}};

    // Reference model state and scoreboard counters
    logic [DW-1:0] ref_mem [DEPTH];
    initial for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];
    int            wc_q[$];
    logic [AW-1:0] ra_q[$];
    int            rc_q[$];
    logic [DW-1:0] rv_q[$];
    int            rvc_q[$];
    int            dn_q[$];
    int            dn_busy = 0;
    int            wr_ready_low = 0;
    logic [DW-1:0] exp_wd[$];

    // Passive monitor: bus ownership check every cycle plus transaction logging
    always @(negedge clk) begin
        logic ok;
        if (ram_cs && ram_oe && !ram_we) ok = (ram_data === ram_rd_q);
        else if (ram_cs && ram_we)       ok = !ram_oe && (ram_data === wr_data);
        else                             ok = 1'b1;
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL bus_owner cyc=%0d cs=%b we=%b oe=%b bus=%h ram=%h wr=%h",
                      cyc, ram_cs, ram_we, ram_oe, ram_data, ram_rd_q, wr_data);
        if (ram_cs && ram_we) begin wa_q.push_back(ram_addr); wd_q.push_back(ram_data); wc_q.push_back(cyc); end
        if (ram_cs && !ram_we) begin ra_q.push_back(ram_addr); rc_q.push_back(cyc); end
        if (rd_valid) begin rv_q.push_back(rd_data); rvc_q.push_back(cyc); end
        if (done) begin
            dn_q.push_back(cyc);
            if (ram_cs || ram_oe || ram_we) dn_busy++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wa_q.delete(); wd_q.delete(); wc_q.delete(); ra_q.delete(); rc_q.delete();
        rv_q.delete(); rvc_q.delete(); dn_q.delete(); exp_wd.delete();
        dn_busy = 0;
        wr_ready_low = 0;
    endtask

    // Present a request once the controller is idle, hold it for the accepting edge.
    task automatic request(input logic wr, input logic [AW-1:0] a, input logic [AW-1:0] l);
        int n = 0;
        while (!req_ready && n < 60) begin tick(); n++; end
        n_total++;
        if (req_ready) n_pass++;
        else $display("FAIL req_accept timeout req_ready=%b required 1", req_ready);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_len = l;
        tick();
        req_valid = 1'b0; req_write = 1'b0;
        req_addr = AW'($urandom); req_len = AW'($urandom);
    endtask

    // Stream len+1 write beats; mode 0 = held valid, 1 = toggling, 2 = random.
    task automatic write_beats(input logic [AW-1:0] l, input int mode);
        int k = 0;
        int guard = 0;
        logic v;
        while (k <= int'(l) && guard < 300) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (guard % 2 == 0) : 1'($urandom_range(0, 1));
            wr_valid = v;
            wr_data = DW'($urandom);
            if (!wr_ready) wr_ready_low++;
            if (v) begin exp_wd.push_back(wr_data); k++; end
            tick();
            guard++;
        end
        wr_valid = 1'b0;
        n_total++;
        if (k > int'(l)) n_pass++;
        else $display("FAIL write_beats timeout beats=%0d required %0d", k, int'(l) + 1);
    endtask

    task automatic commit_ref(input logic [AW-1:0] a);
        for (int i = 0; i < exp_wd.size(); i++) ref_mem[(int'(a) + i) % DEPTH] = exp_wd[i];
    endtask

    task automatic test_reset();
        req_valid = 1'b0; wr_valid = 1'b0; rst_n = 1'b0;
        tick(); tick();
        n_total++;
        if ({wr_ready, rd_valid, rd_data, done, ram_cs, ram_we, ram_oe, ram_addr} !== '0)
            $display("FAIL reset_outputs got wr_rdy=%b rdv=%b rdd=%h done=%b cs=%b we=%b oe=%b addr=%h required all 0",
                     wr_ready, rd_valid, rd_data, done, ram_cs, ram_we, ram_oe, ram_addr);
        else n_pass++;
        rst_n = 1'b1;
        tick();
        n_total++;
        if (req_ready !== 1'b1 || done !== 1'b0 || ram_cs !== 1'b0)
            $display("FAIL reset_release req_ready=%b done=%b cs=%b required 1/0/0", req_ready, done, ram_cs);
        else n_pass++;
    endtask

    task automatic test_write_full();
        clear_logs();
        request(1'b1, 4'd0, 4'd15);
        write_beats(4'd15, 0);
        repeat (3) tick();
        commit_ref(4'd0);
        n_total++;
        if (wa_q.size() != 16) $display("FAIL wfull_count got %0d required 16", wa_q.size());
        else begin
            n_pass++;
            for (int i = 0; i < 16; i++) begin
                n_total++;
                if (wa_q[i] !== AW'(i) || wd_q[i] !== exp_wd[i] || wc_q[i] != wc_q[0] + i)
                    $display("FAIL wfull_beat%0d addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                             i, wa_q[i], wd_q[i], wc_q[i], AW'(i), exp_wd[i], wc_q[0] + i);
                else n_pass++;
            end
            n_total++;
            if (dn_q.size() != 1 || dn_q[0] != wc_q[15] + 1)
                $display("FAIL wfull_done pulses=%0d first=%0d required 1 at %0d",
                         dn_q.size(), (dn_q.size() > 0) ? dn_q[0] : -1, wc_q[15] + 1);
            else n_pass++;
        end
        n_total++;
        if (wr_ready_low != 0) $display("FAIL wfull_wr_ready low_cycles=%0d required 0", wr_ready_low);
        else n_pass++;
    endtask

    task automatic test_read_back(input logic [AW-1:0] a, input logic [AW-1:0] l);
        int nb = int'(l) + 1;
        clear_logs();
        request(1'b0, a, l);
        for (int i = 0; i < nb + 6; i++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_data = DW'($urandom);
            tick();
        end
        wr_valid = 1'b0;
        n_total++;
        if (rv_q.size() != nb || ra_q.size() != nb + 1 || wa_q.size() != 0)
            $display("FAIL rd_counts a=%0d l=%0d rdv=%0d addr_cycles=%0d writes=%0d required %0d/%0d/0",
                     a, l, rv_q.size(), ra_q.size(), wa_q.size(), nb, nb + 1);
        else begin
            n_pass++;
            for (int i = 0; i < nb; i++) begin
                n_total++;
                if (rv_q[i] !== ref_mem[(int'(a) + i) % DEPTH] || ra_q[i] !== AW'((int'(a) + i) % DEPTH)
                    || rvc_q[i] != rc_q[0] + 2 + i)
                    $display("FAIL rd_beat%0d data=%h addr=%h cyc=%0d required data=%h addr=%h cyc=%0d",
                             i, rv_q[i], ra_q[i], rvc_q[i], ref_mem[(int'(a) + i) % DEPTH],
                             AW'((int'(a) + i) % DEPTH), rc_q[0] + 2 + i);
                else n_pass++;
            end
            n_total++;
            if (dn_q.size() != 1 || dn_q[0] != rvc_q[nb - 1] || dn_busy != 0)
                $display("FAIL rd_done pulses=%0d at=%0d busy=%0d required 1 at %0d idle bus",
                         dn_q.size(), (dn_q.size() > 0) ? dn_q[0] : -1, dn_busy, rvc_q[nb - 1]);
            else n_pass++;
        end
    endtask

    task automatic test_wrap_toggle();
        clear_logs();
        request(1'b1, 4'd14, 4'd3);
        write_beats(4'd3, 1);
        repeat (3) tick();
        commit_ref(4'd14);
        n_total++;
        if (wa_q.size() != 4) $display("FAIL wrap_count got %0d required 4", wa_q.size());
        else begin
            n_pass++;
            for (int i = 0; i < 4; i++) begin
                n_total++;
                if (wa_q[i] !== AW'((14 + i) % 16) || wd_q[i] !== exp_wd[i] || (i > 0 && wc_q[i] != wc_q[i-1] + 2))
                    $display("FAIL wrap_beat%0d addr=%h data=%h required addr=%h data=%h spacing 2",
                             i, wa_q[i], wd_q[i], AW'((14 + i) % 16), exp_wd[i]);
                else n_pass++;
            end
        end
        n_total++;
        if (dn_q.size() != 1) $display("FAIL wrap_done pulses=%0d required 1", dn_q.size());
        else n_pass++;
    endtask

    task automatic test_read_then_write();
        int n = 0;
        clear_logs();
        request(1'b0, 4'd5, 4'd2);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd9; req_len = 4'd1;
        while (!req_ready && n < 60) begin tick(); n++; end
        tick();
        req_valid = 1'b0;
        write_beats(4'd1, 0);
        repeat (3) tick();
        n_total++;
        if (rv_q.size() != 3 || wa_q.size() != 2 || dn_q.size() != 2)
            $display("FAIL rtw_counts rdv=%0d writes=%0d done=%0d required 3/2/2", rv_q.size(), wa_q.size(), dn_q.size());
        else begin
            n_pass++;
            for (int i = 0; i < 3; i++) begin
                n_total++;
                if (rv_q[i] !== ref_mem[5 + i]) $display("FAIL rtw_rd%0d got %h required %h", i, rv_q[i], ref_mem[5 + i]);
                else n_pass++;
            end
            n_total++;
            if (wa_q[0] !== 4'd9 || wa_q[1] !== 4'd10 || wc_q[0] != dn_q[0] + 2 || dn_busy != 0)
                $display("FAIL rtw_write addr0=%h addr1=%h cyc=%0d busy=%0d required 9/a at %0d idle turn",
                         wa_q[0], wa_q[1], wc_q[0], dn_busy, dn_q[0] + 2);
            else n_pass++;
        end
        commit_ref(4'd9);
    endtask

    task automatic test_reset_mid_read();
        clear_logs();
        request(1'b0, 4'd0, 4'd15);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({wr_ready, rd_valid, rd_data, done, ram_cs, ram_we, ram_oe, ram_addr} !== '0)
            $display("FAIL midrst_outputs rdv=%b rdd=%h done=%b cs=%b oe=%b addr=%h required all 0",
                     rd_valid, rd_data, done, ram_cs, ram_oe, ram_addr);
        else n_pass++;
        tick(); tick();
        rst_n = 1'b1;
        repeat (3) tick();
        n_total++;
        if (dn_q.size() != 0) $display("FAIL midrst_done pulses=%0d required 0", dn_q.size());
        else n_pass++;
        clear_logs();
        request(1'b1, 4'd3, 4'd0);
        write_beats(4'd0, 0);
        repeat (3) tick();
        commit_ref(4'd3);
        n_total++;
        if (wa_q.size() != 1 || wa_q[0] !== 4'd3 || wd_q[0] !== exp_wd[0] || dn_q.size() != 1)
            $display("FAIL midrst_write writes=%0d done=%0d required 1 write at 3 and 1 done", wa_q.size(), dn_q.size());
        else n_pass++;
        test_read_back(4'd3, 4'd0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            logic [AW-1:0] a = AW'($urandom);
            logic [AW-1:0] l = AW'($urandom);
            if (it % 2 == 1) begin
                test_read_back(a, l);
            end else begin
                clear_logs();
                request(1'b1, a, l);
                write_beats(l, 2);
                repeat (3) tick();
                commit_ref(a);
                n_total++;
                if (wa_q.size() != int'(l) + 1 || dn_q.size() != 1)
                    $display("FAIL rnd_wr_count it=%0d writes=%0d done=%0d required %0d/1", it, wa_q.size(), dn_q.size(), int'(l) + 1);
                else begin
                    n_pass++;
                    for (int i = 0; i <= int'(l); i++) begin
                        n_total++;
                        if (wa_q[i] !== AW'((int'(a) + i) % DEPTH) || wd_q[i] !== exp_wd[i])
                            $display("FAIL rnd_wr it=%0d beat%0d addr=%h data=%h required %h/%h",
                                     it, i, wa_q[i], wd_q[i], AW'((int'(a) + i) % DEPTH), exp_wd[i]);
                        else n_pass++;
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_full();
        test_read_back(4'd0, 4'd15);
        test_wrap_toggle();
        test_read_back(4'd14, 4'd3);
        test_read_then_write();
        test_reset_mid_read();
        test_random();
        test_read_back(4'd0, 4'd15);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
